mvm_sequencer: RTL

//  Host-side controller for the sparse MVM accelerator. Buffers up to MAX_NNZ CSR entries and one spike train from a

---
 rtl/mvm_pkg.sv | 33 +++
 rtl/csr_entry_buffer.sv | 29 ++
 rtl/mvm_sequencer.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/mvm_pkg.sv
// Shared definitions for the sparse MVM host sequencer: state encoding,
// host word kinds, default geometry and the watchdog limit.
package mvm_pkg;

  localparam int MAX_NNZ_D = 9;
  localparam int ROWS_D    = 3;
  localparam int VAL_W_D   = 8;
  localparam int IDX_W_D   = 2;
  localparam int WD_MAX_D  = 255;

  typedef enum logic [2:0] {
    ST_LOAD    = 3'd0,
    ST_START   = 3'd1,
    ST_SEND    = 3'd2,
    ST_GAP     = 3'd3,
    ST_DONE    = 3'd4,
    ST_TRAIN   = 3'd5,
    ST_COLLECT = 3'd6,
    ST_DRAIN   = 3'd7
  } state_t;

  typedef logic [1:0] kind_t;

  localparam kind_t KIND_ENTRY = 2'b00;
  localparam kind_t KIND_SPIKE = 2'b01;
  localparam kind_t KIND_GO    = 2'b10;

  // States in which the sequencer waits on the accelerator and the watchdog runs.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_SEND) || (s == ST_TRAIN) || (s == ST_COLLECT);
  endfunction

endpackage

// File: rtl/csr_entry_buffer.sv
// CSR entry storage: one write port, one asynchronous read port.
// Storage is not reset; validity is tracked by the sequencer's entry count.
module csr_entry_buffer #(
  parameter int DEPTH = 9,
  parameter int WIDTH = 12,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port; the caller guarantees i_waddr < DEPTH when i_we is high.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read port returns zero for the one-past-end address the pointer can reach.
  always_comb begin
    o_rdata = '0;
    if (i_raddr < AW'(DEPTH)) o_rdata = r_mem[i_raddr];
  end

endmodule

// File: rtl/mvm_sequencer.sv
// Host-side controller for the sparse MVM accelerator: buffers CSR entries and
// a spike train, replays them over the fetch handshake, collects the results.
//
// state   | meaning
// LOAD    | accept host words (entries, spike train, GO)
// START   | acc_start pulse
// SEND    | wait for fetch_ready, then strobe buf[ptr]
// GAP     | one idle cycle between entry strobes
// DONE    | acc_done_list pulse
// TRAIN   | wait for fetch_ready, then strobe the spike train
// COLLECT | first result toggle = compute done, next ROWS toggles = results
// DRAIN   | hand results to the host one word at a time
module mvm_sequencer
  import mvm_pkg::*;
#(
  parameter int MAX_NNZ = MAX_NNZ_D,
  parameter int ROWS    = ROWS_D,
  parameter int VAL_W   = VAL_W_D,
  parameter int IDX_W   = IDX_W_D,
  parameter int WD_MAX  = WD_MAX_D
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             host_valid,
  output logic             host_ready,
  input  logic [1:0]       host_kind,
  input  logic [IDX_W-1:0] host_row,
  input  logic [IDX_W-1:0] host_col,
  input  logic [VAL_W-1:0] host_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [VAL_W-1:0] res_data,
  output logic [IDX_W-1:0] res_idx,
  output logic             busy,
  output logic             err,
  output logic             acc_rst,
  output logic             acc_start,
  output logic             acc_sending,
  output logic             acc_done_list,
  output logic [IDX_W-1:0] acc_row,
  output logic [IDX_W-1:0] acc_col,
  output logic [VAL_W-1:0] acc_value,
  input  logic             acc_fetch_ready,
  input  logic             acc_sending_out,
  input  logic [VAL_W-1:0] acc_output_val
);

  localparam int CW  = $clog2(MAX_NNZ + 1);
  localparam int KW  = $clog2(ROWS + 1);
  localparam int WDW = $clog2(WD_MAX + 1);
  localparam int EW  = 2 * IDX_W + VAL_W;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_ptr;
  logic [KW-1:0]    r_k;
  logic [ROWS-1:0]  r_spike;
  logic             r_err;
  logic             r_tog;
  logic             r_seen_first;
  logic [WDW-1:0]   r_wd;
  logic [VAL_W-1:0] r_res_buf [ROWS];

  logic             w_accept;
  logic             w_toggle;
  logic             w_wd_exp;
  logic             w_last_xfer;
  logic             w_capture;
  logic             w_buf_we;
  logic             w_start_nxt;
  logic             w_send_entry;
  logic             w_send_train;
  logic             w_done_nxt;
  logic [EW-1:0]    w_rd_entry;

  assign w_accept    = host_valid && (r_state == ST_LOAD);
  assign w_toggle    = acc_sending_out ^ r_tog;
  assign w_wd_exp    = is_wait_state(r_state) && (r_wd == WDW'(WD_MAX));
  assign w_last_xfer = (r_state == ST_DRAIN) && res_ready && (r_k == KW'(ROWS - 1));
  assign w_capture   = (r_state == ST_COLLECT) && w_toggle && r_seen_first && !w_wd_exp;
  assign w_buf_we    = w_accept && (host_kind == KIND_ENTRY) && (r_count < CW'(MAX_NNZ));
  assign err         = r_err;

  csr_entry_buffer #(
    .DEPTH (MAX_NNZ),
    .WIDTH (EW),
    .AW    (CW)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_buf_we),
    .i_waddr (r_count),
    .i_wdata ({host_row, host_col, host_data}),
    .i_raddr (r_ptr),
    .o_rdata (w_rd_entry)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_LOAD;
    else        r_state <= w_next;
  end

  // Next-state logic; watchdog expiry overrides any accelerator event.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_LOAD:    if (w_accept && (host_kind == KIND_GO) && (r_count != '0)) w_next = ST_START;
      ST_START:   w_next = ST_SEND;
      ST_SEND:    if (w_wd_exp) w_next = ST_LOAD;
                  else if (acc_fetch_ready) w_next = ST_GAP;
      ST_GAP:     w_next = (r_ptr < r_count) ? ST_SEND : ST_DONE;
      ST_DONE:    w_next = ST_TRAIN;
      ST_TRAIN:   if (w_wd_exp) w_next = ST_LOAD;
                  else if (acc_fetch_ready) w_next = ST_COLLECT;
      ST_COLLECT: if (w_wd_exp) w_next = ST_LOAD;
                  else if (w_capture && (r_k == KW'(ROWS - 1))) w_next = ST_DRAIN;
      ST_DRAIN:   if (w_last_xfer) w_next = ST_LOAD;
      default:    w_next = ST_LOAD;
    endcase
  end

  // Output decode: accelerator strobes are computed from the transition and registered below.
  always_comb begin
    w_start_nxt  = (r_state == ST_LOAD)  && (w_next == ST_START);
    w_send_entry = (r_state == ST_SEND)  && (w_next == ST_GAP);
    w_send_train = (r_state == ST_TRAIN) && (w_next == ST_COLLECT);
    w_done_nxt   = (r_state == ST_GAP)   && (w_next == ST_DONE);
    host_ready   = (r_state == ST_LOAD);
    busy         = (r_state != ST_LOAD);
    res_valid    = (r_state == ST_DRAIN);
    res_data     = r_res_buf[r_k];
    res_idx      = IDX_W'(r_k);
  end

  // Datapath: counters, error flag, watchdog and registered accelerator outputs.
  always_ff @(posedge clk) begin
    r_tog <= acc_sending_out;
    if (!rst_n) begin
      r_count       <= '0;
      r_ptr         <= '0;
      r_k           <= '0;
      r_spike       <= '0;
      r_err         <= 1'b0;
      r_seen_first  <= 1'b0;
      r_wd          <= '0;
      acc_rst       <= 1'b1;
      acc_start     <= 1'b0;
      acc_sending   <= 1'b0;
      acc_done_list <= 1'b0;
      acc_row       <= '0;
      acc_col       <= '0;
      acc_value     <= '0;
    end else begin
      acc_rst       <= w_wd_exp;
      acc_start     <= w_start_nxt;
      acc_sending   <= w_send_entry || w_send_train;
      acc_done_list <= w_done_nxt;

      if (w_next != r_state)        r_wd <= '0;
      else if (is_wait_state(r_state)) r_wd <= r_wd + 1'b1;
      else                          r_wd <= '0;

      if (w_send_entry) begin
        {acc_row, acc_col, acc_value} <= w_rd_entry;
        r_ptr <= r_ptr + 1'b1;
      end
      if (w_send_train) begin
        acc_value    <= VAL_W'(r_spike);
        r_seen_first <= 1'b0;
      end

      if (w_accept) begin
        case (host_kind)
          KIND_ENTRY: if (r_count < CW'(MAX_NNZ)) r_count <= r_count + 1'b1;
                      else r_err <= 1'b1;
          KIND_SPIKE: r_spike <= host_data[ROWS-1:0];
          KIND_GO:    r_err <= (r_count == '0);
          default:    ;
        endcase
      end

      if ((r_state == ST_COLLECT) && w_toggle && !w_wd_exp && !r_seen_first) r_seen_first <= 1'b1;
      if (w_capture) r_k <= (r_k == KW'(ROWS - 1)) ? '0 : r_k + 1'b1;
      if ((r_state == ST_DRAIN) && res_ready) r_k <= r_k + 1'b1;

      if (w_last_xfer || w_wd_exp) begin
        r_count <= '0;
        r_ptr   <= '0;
        r_k     <= '0;
        r_spike <= '0;
      end
      if (w_wd_exp) r_err <= 1'b1;
    end
  end

  // Result capture; storage needs no reset since it is only read in DRAIN.
  always_ff @(posedge clk) begin
    if (w_capture) r_res_buf[r_k] <= acc_output_val;
  end

endmodule
